// File: rtl/game_pkg.sv
// Shared types and constants for the game controller front end.
// Button indices map raw inputs into the debouncer bank.
package game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        REPEAT = 2'b10
    } move_state_e;

    localparam int NUM_BTNS   = 7;
    localparam int BTN_START  = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_RIGHT  = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_LEFT   = 4;
    localparam int BTN_ATTACK = 5;
    localparam int BTN_DEFEND = 6;

    // Left is the fallback, so callers must only use this while some direction is held.
    function automatic dir_e pick_dir(input logic up, input logic right, input logic down);
        if (up) begin
            return DIR_UP;
        end else if (right) begin
            return DIR_RIGHT;
        end else if (down) begin
            return DIR_DOWN;
        end
        return DIR_LEFT;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce counter and rise detector.
// o_rise is high for the single cycle in which the debounced level goes 0 -> 1.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             deb_q;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= i_raw;
            sync_q2 <= sync_q1;
        end
    end

    // The level only follows after the synchronised input has differed for a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            deb_prev_q <= deb_q;
            if (sync_q2 == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_q <= sync_q2;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_level = deb_q;
    assign o_rise  = deb_q & ~deb_prev_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Turns raw board buttons into clean game commands: start pulse, direction with
// auto-repeat move pulses, cooldown-limited attack pulse and defend level.
module player_input_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int ATTACK_COOLDOWN = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_start,
    input  logic       i_btn_up,
    input  logic       i_btn_right,
    input  logic       i_btn_down,
    input  logic       i_btn_left,
    input  logic       i_btn_attack,
    input  logic       i_btn_defend,
    output logic       o_start,
    output logic [1:0] o_dir,
    output logic       o_move,
    output logic       o_attack,
    output logic       o_defend,
    output logic       o_attack_ready
);

    localparam int RCNT_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int RCNT_W   = $clog2(RCNT_MAX + 1);
    localparam int CD_W     = $clog2(ATTACK_COOLDOWN + 1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_rise;

    assign btn_raw = {i_btn_defend, i_btn_attack, i_btn_left, i_btn_down,
                      i_btn_right, i_btn_up, i_btn_start};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (btn_raw[i]),
            .o_level(btn_level[i]),
            .o_rise (btn_rise[i])
        );
    end

    // Start and attack act on edges, directions and defend on levels.
    logic unused_btn_bits;
    assign unused_btn_bits = &{1'b0, btn_level[BTN_START], btn_level[BTN_ATTACK],
                               btn_rise[BTN_UP], btn_rise[BTN_RIGHT], btn_rise[BTN_DOWN],
                               btn_rise[BTN_LEFT], btn_rise[BTN_DEFEND]};

    logic any_held;
    dir_e active_dir;

    assign any_held   = btn_level[BTN_UP] | btn_level[BTN_RIGHT] |
                        btn_level[BTN_DOWN] | btn_level[BTN_LEFT];
    assign active_dir = pick_dir(btn_level[BTN_UP], btn_level[BTN_RIGHT], btn_level[BTN_DOWN]);

    move_state_e       state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    dir_e              dir_q, dir_d;
    logic              move_q, move_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            dir_q   <= DIR_UP;
            move_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            dir_q   <= dir_d;
            move_q  <= move_d;
        end
    end

    // A change of active direction restarts the sequence exactly like a fresh press.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        dir_d   = dir_q;
        move_d  = 1'b0;
        if (!any_held) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else if (state_q == IDLE || active_dir != dir_q) begin
            move_d  = 1'b1;
            rcnt_d  = '0;
            state_d = DELAY;
            dir_d   = active_dir;
        end else begin
            case (state_q)
                DELAY: begin
                    if (rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) begin
                        move_d  = 1'b1;
                        rcnt_d  = '0;
                        state_d = REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rcnt_q == RCNT_W'(REPEAT_CYCLES - 1)) begin
                        move_d = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    logic [CD_W-1:0] cooldown_q, cooldown_d;
    logic            attack_accept;

    // Defend level blocks attacks, which also covers defend rising on the same cycle.
    assign attack_accept = btn_rise[BTN_ATTACK] && (cooldown_q == '0) && !btn_level[BTN_DEFEND];

    always_comb begin
        cooldown_d = cooldown_q;
        if (attack_accept) begin
            cooldown_d = CD_W'(ATTACK_COOLDOWN);
        end else if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - 1'b1;
        end
    end

    logic start_q, attack_q, defend_q, ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cooldown_q <= '0;
            start_q    <= 1'b0;
            attack_q   <= 1'b0;
            defend_q   <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            cooldown_q <= cooldown_d;
            start_q    <= btn_rise[BTN_START];
            attack_q   <= attack_accept;
            defend_q   <= btn_level[BTN_DEFEND];
            ready_q    <= (cooldown_d == '0);
        end
    end

    assign o_start        = start_q;
    assign o_dir          = dir_q;
    assign o_move         = move_q;
    assign o_attack       = attack_q;
    assign o_defend       = defend_q;
    assign o_attack_ready = ready_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench for player_input_ctrl: each scenario queues the pulses it
// expects (edge number and direction) and a negedge monitor pops them as they appear.
module tb_player_input_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0, btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0;
    logic       btn_left = 1'b0, btn_attack = 1'b0, btn_defend = 1'b0;
    logic       o_start, o_move, o_attack, o_defend, o_attack_ready;
    logic [1:0] o_dir;

    int edge_cnt = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;
    int start_seen = 0;
    int attack_seen = 0;

    typedef struct {
        int         edge_no;
        logic [1:0] dir;
    } move_exp_t;

    int        start_exp[$];
    int        attack_exp[$];
    move_exp_t move_exp[$];

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_CYCLES  (4),
        .ATTACK_COOLDOWN(10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn_start   (btn_start),
        .i_btn_up      (btn_up),
        .i_btn_right   (btn_right),
        .i_btn_down    (btn_down),
        .i_btn_left    (btn_left),
        .i_btn_attack  (btn_attack),
        .i_btn_defend  (btn_defend),
        .o_start       (o_start),
        .o_dir         (o_dir),
        .o_move        (o_move),
        .o_attack      (o_attack),
        .o_defend      (o_defend),
        .o_attack_ready(o_attack_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Every observed pulse must match the head of its queue.
    always @(negedge clk) begin
        if (o_start) begin
            int exp_e;
            start_seen++;
            chk_cnt++;
            if (start_exp.size() == 0) begin
                $display("[TB] FAIL start_pulse: pulse at edge %0d, expected none", edge_cnt);
            end else begin
                exp_e = start_exp.pop_front();
                if (edge_cnt !== exp_e)
                    $display("[TB] FAIL start_pulse: edge %0d, expected edge %0d", edge_cnt, exp_e);
                else
                    pass_cnt++;
            end
        end
        if (o_attack) begin
            int exp_e;
            attack_seen++;
            chk_cnt++;
            if (attack_exp.size() == 0) begin
                $display("[TB] FAIL attack_pulse: pulse at edge %0d, expected none", edge_cnt);
            end else begin
                exp_e = attack_exp.pop_front();
                if (edge_cnt !== exp_e)
                    $display("[TB] FAIL attack_pulse: edge %0d, expected edge %0d", edge_cnt, exp_e);
                else
                    pass_cnt++;
            end
        end
        if (o_move) begin
            move_exp_t m;
            chk_cnt++;
            if (move_exp.size() == 0) begin
                $display("[TB] FAIL move_pulse: pulse at edge %0d dir %0b, expected none",
                         edge_cnt, o_dir);
            end else begin
                m = move_exp.pop_front();
                if (edge_cnt !== m.edge_no || o_dir !== m.dir)
                    $display("[TB] FAIL move_pulse: edge %0d dir %0b, expected edge %0d dir %0b",
                             edge_cnt, o_dir, m.edge_no, m.dir);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic push_move(input int e, input logic [1:0] d);
        move_exp_t m;
        m.edge_no = e;
        m.dir     = d;
        move_exp.push_back(m);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        chk_cnt++; if (o_start !== 1'b0) $display("[TB] FAIL reset_start: got %b want 0", o_start); else pass_cnt++;
        chk_cnt++; if (o_dir !== 2'b00) $display("[TB] FAIL reset_dir: got %b want 00", o_dir); else pass_cnt++;
        chk_cnt++; if (o_move !== 1'b0) $display("[TB] FAIL reset_move: got %b want 0", o_move); else pass_cnt++;
        chk_cnt++; if (o_attack !== 1'b0) $display("[TB] FAIL reset_attack: got %b want 0", o_attack); else pass_cnt++;
        chk_cnt++; if (o_defend !== 1'b0) $display("[TB] FAIL reset_defend: got %b want 0", o_defend); else pass_cnt++;
        chk_cnt++; if (o_attack_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", o_attack_ready); else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_glitch();
        int seen0 = start_seen;
        @(negedge clk);
        btn_start = 1'b1;
        repeat (3) @(negedge clk);
        btn_start = 1'b0;
        repeat (12) @(negedge clk);
        chk_cnt++;
        if (start_seen !== seen0) $display("[TB] FAIL start_glitch: %0d pulses, want 0", start_seen - seen0);
        else pass_cnt++;
    endtask

    task automatic test_start_hold();
        int seen0 = start_seen;
        int base;
        @(negedge clk);
        base = edge_cnt;
        btn_start = 1'b1;
        start_exp.push_back(base + 7);
        repeat (20) @(negedge clk);
        btn_start = 1'b0;
        repeat (10) @(negedge clk);
        chk_cnt++;
        if (start_seen !== seen0 + 1 || start_exp.size() !== 0)
            $display("[TB] FAIL start_hold: %0d pulses, %0d missing, want 1 and 0",
                     start_seen - seen0, start_exp.size());
        else pass_cnt++;
    endtask

    task automatic test_move_repeat();
        int base;
        @(negedge clk);
        base = edge_cnt;
        btn_right = 1'b1;
        push_move(base + 7, 2'b01);
        push_move(base + 15, 2'b01);
        for (int e = 19; e <= 29 + 6; e += 4) push_move(base + e, 2'b01);
        repeat (29) @(negedge clk);
        btn_right = 1'b0;
        repeat (15) @(negedge clk);
        chk_cnt++;
        if (o_dir !== 2'b01) $display("[TB] FAIL repeat_dir_hold: got %b want 01", o_dir); else pass_cnt++;
        chk_cnt++;
        if (move_exp.size() !== 0) $display("[TB] FAIL repeat_drain: %0d pulses missing, want 0", move_exp.size());
        else pass_cnt++;
    endtask

    task automatic test_dir_priority();
        int base;
        @(negedge clk);
        base = edge_cnt;
        btn_left = 1'b1;
        push_move(base + 7, 2'b11);
        push_move(base + 11, 2'b00);
        push_move(base + 19, 2'b00);
        push_move(base + 21, 2'b11);
        repeat (4) @(negedge clk);
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (8) @(negedge clk);
        btn_left = 1'b0;
        repeat (12) @(negedge clk);
        chk_cnt++;
        if (o_dir !== 2'b11) $display("[TB] FAIL priority_dir: got %b want 11", o_dir); else pass_cnt++;
        chk_cnt++;
        if (move_exp.size() !== 0) $display("[TB] FAIL priority_drain: %0d pulses missing, want 0", move_exp.size());
        else pass_cnt++;
    endtask

    task automatic test_attack_cooldown();
        int base;
        @(negedge clk);
        base = edge_cnt;
        btn_attack = 1'b1;
        attack_exp.push_back(base + 7);
        repeat (4) @(negedge clk);
        btn_attack = 1'b0;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (o_attack_ready !== 1'b0) $display("[TB] FAIL cooldown_ready_low: got %b want 0", o_attack_ready); else pass_cnt++;
        repeat (2) @(negedge clk);
        btn_attack = 1'b1;
        repeat (5) @(negedge clk);
        btn_attack = 1'b0;
        repeat (1) @(negedge clk);
        chk_cnt++;
        if (o_attack_ready !== 1'b0) $display("[TB] FAIL cooldown_ready_last: got %b want 0", o_attack_ready); else pass_cnt++;
        repeat (1) @(negedge clk);
        chk_cnt++;
        if (o_attack_ready !== 1'b1) $display("[TB] FAIL cooldown_ready_back: got %b want 1", o_attack_ready); else pass_cnt++;
        repeat (5) @(negedge clk);
        btn_attack = 1'b1;
        attack_exp.push_back(base + 29);
        repeat (5) @(negedge clk);
        btn_attack = 1'b0;
        repeat (20) @(negedge clk);
        chk_cnt++;
        if (attack_exp.size() !== 0) $display("[TB] FAIL cooldown_drain: %0d pulses missing, want 0", attack_exp.size());
        else pass_cnt++;
    endtask

    task automatic test_attack_boundary();
        int base;
        @(negedge clk);
        base = edge_cnt;
        btn_attack = 1'b1;
        attack_exp.push_back(base + 7);
        repeat (4) @(negedge clk);
        btn_attack = 1'b0;
        repeat (7) @(negedge clk);
        btn_attack = 1'b1;
        attack_exp.push_back(base + 18);
        repeat (5) @(negedge clk);
        btn_attack = 1'b0;
        chk_cnt++;
        if (o_attack_ready !== 1'b0) $display("[TB] FAIL boundary_ready_low: got %b want 0", o_attack_ready); else pass_cnt++;
        repeat (1) @(negedge clk);
        chk_cnt++;
        if (o_attack_ready !== 1'b1) $display("[TB] FAIL boundary_ready_zero: got %b want 1", o_attack_ready); else pass_cnt++;
        repeat (1) @(negedge clk);
        chk_cnt++;
        if (o_attack_ready !== 1'b0) $display("[TB] FAIL boundary_reaccept: got %b want 0", o_attack_ready); else pass_cnt++;
        repeat (20) @(negedge clk);
        chk_cnt++;
        if (attack_exp.size() !== 0) $display("[TB] FAIL boundary_drain: %0d pulses missing, want 0", attack_exp.size());
        else pass_cnt++;
    endtask

    task automatic test_defend();
        int seen0 = attack_seen;
        @(negedge clk);
        btn_defend = 1'b1;
        repeat (6) @(negedge clk);
        chk_cnt++;
        if (o_defend !== 1'b0) $display("[TB] FAIL defend_early: got %b want 0", o_defend); else pass_cnt++;
        repeat (1) @(negedge clk);
        chk_cnt++;
        if (o_defend !== 1'b1) $display("[TB] FAIL defend_level: got %b want 1", o_defend); else pass_cnt++;
        repeat (3) @(negedge clk);
        btn_attack = 1'b1;
        repeat (5) @(negedge clk);
        btn_attack = 1'b0;
        repeat (5) @(negedge clk);
        chk_cnt++;
        if (o_attack_ready !== 1'b1) $display("[TB] FAIL defend_cooldown: got %b want 1", o_attack_ready); else pass_cnt++;
        btn_defend = 1'b0;
        repeat (12) @(negedge clk);
        chk_cnt++;
        if (o_defend !== 1'b0) $display("[TB] FAIL defend_release: got %b want 0", o_defend); else pass_cnt++;
        btn_defend = 1'b1;
        btn_attack = 1'b1;
        repeat (5) @(negedge clk);
        btn_attack = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (o_defend !== 1'b1 || o_attack_ready !== 1'b1)
            $display("[TB] FAIL defend_same_cycle: defend %b ready %b, want 1 1", o_defend, o_attack_ready);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        btn_defend = 1'b0;
        repeat (12) @(negedge clk);
        chk_cnt++;
        if (attack_seen !== seen0) $display("[TB] FAIL defend_no_attack: %0d pulses, want 0", attack_seen - seen0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int base;
        @(negedge clk);
        base = edge_cnt;
        btn_right = 1'b1;
        push_move(base + 7, 2'b01);
        push_move(base + 15, 2'b01);
        push_move(base + 19, 2'b01);
        repeat (21) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (o_dir !== 2'b00 || o_move !== 1'b0 || o_attack_ready !== 1'b1 || o_defend !== 1'b0)
            $display("[TB] FAIL async_reset: dir %b move %b ready %b defend %b, want 00 0 1 0",
                     o_dir, o_move, o_attack_ready, o_defend);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = edge_cnt;
        push_move(base + 7, 2'b01);
        push_move(base + 15, 2'b01);
        repeat (12) @(negedge clk);
        btn_right = 1'b0;
        repeat (15) @(negedge clk);
        chk_cnt++;
        if (move_exp.size() !== 0) $display("[TB] FAIL reset_mid_drain: %0d pulses missing, want 0", move_exp.size());
        else pass_cnt++;
        chk_cnt++;
        if (o_dir !== 2'b01) $display("[TB] FAIL reset_mid_dir: got %b want 01", o_dir); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_start_glitch();
        test_start_hold();
        test_move_repeat();
        test_dir_priority();
        test_attack_cooldown();
        test_attack_boundary();
        test_defend();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
